// File: rtl/chacha_chunk_server_pkg.sv
// Shared definitions for the ChaCha20 key/nonce/counter chunk server.
// Holds the response type encodings, the cfg register address map, the
// server FSM state encoding and the key/nonce word counts.
package chacha_chunk_pkg;

  typedef enum logic [1:0] {
    CHUNK_KEY     = 2'd0,
    CHUNK_NONCE   = 2'd1,
    CHUNK_COUNTER = 2'd2,
    CHUNK_RSVD    = 2'd3
  } chunk_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam int unsigned KEY_WORDS   = 8;
  localparam int unsigned NONCE_WORDS = 3;

  // cfg address map: 0-7 key, 8-10 nonce, 11 counter, 12 control, 13-15 ignored
  localparam logic [3:0] ADDR_KEY0    = 4'd0;
  localparam logic [3:0] ADDR_NONCE0  = 4'd8;
  localparam logic [3:0] ADDR_COUNTER = 4'd11;
  localparam logic [3:0] ADDR_CTRL    = 4'd12;

endpackage

// File: rtl/chacha_chunk_server_if.sv
// Streamed-chunk request/response bundle between the ChaCha20 top-level
// (master: issues chunk_request/request_type/chunk_index) and the chunk
// server (slave: returns chunk/chunk_type/chunk_valid and pending).
interface chacha_chunk_server_if;
  logic        chunk_request;
  logic [1:0]  request_type;
  logic [4:0]  chunk_index;
  logic [31:0] chunk;
  logic [1:0]  chunk_type;
  logic        chunk_valid;
  logic        pending;

  modport master (
    output chunk_request, request_type, chunk_index,
    input  chunk, chunk_type, chunk_valid, pending
  );

  modport slave (
    input  chunk_request, request_type, chunk_index,
    output chunk, chunk_type, chunk_valid, pending
  );
endinterface

// File: rtl/chacha_chunk_server.sv
// Key/nonce/counter source for the ChaCha20 top-level.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   cfg_we/addr/wdata     - firmware register write port (key, nonce, counter, control)
//   chunk_if (slave)      - request in, registered one-cycle response out after LATENCY
//   counter_value         - current stored block counter
//   err                   - sticky, an illegal type/index was served
//   ctr_wrap              - sticky, auto-increment wrapped to zero
module chacha_chunk_server
  import chacha_chunk_pkg::*;
#(
  parameter int unsigned LATENCY = 1  // legal range 1..7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  chacha_chunk_server_if.slave         chunk_if,
  output logic [31:0]                  counter_value,
  output logic                         err,
  output logic                         ctr_wrap
);

  localparam logic [2:0] LAT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  logic [31:0] key_q   [KEY_WORDS];
  logic [31:0] key_d   [KEY_WORDS];
  logic [31:0] nonce_q [NONCE_WORDS];
  logic [31:0] nonce_d [NONCE_WORDS];
  logic [31:0] counter_q, counter_d;
  logic        auto_inc_q, auto_inc_d;
  logic        err_q, err_d;
  logic        ctr_wrap_q, ctr_wrap_d;
  state_e      state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  type_q, type_d;
  logic        bad_q, bad_d;
  logic        ctr_hit_q, ctr_hit_d;
  logic [31:0] chunk_q, chunk_d;
  logic [1:0]  chunk_type_q, chunk_type_d;
  logic        valid_q, valid_d;
  logic        pending_q, pending_d;

  logic [31:0] lookup_data;
  logic        lookup_ok;

  always_comb begin
    lookup_data = '0;
    lookup_ok   = 1'b0;
    case (chunk_if.request_type)
      CHUNK_KEY: if (chunk_if.chunk_index < 5'(KEY_WORDS)) begin
        lookup_data = key_q[chunk_if.chunk_index[2:0]];
        lookup_ok   = 1'b1;
      end
      CHUNK_NONCE: if (chunk_if.chunk_index < 5'(NONCE_WORDS)) begin
        lookup_data = nonce_q[chunk_if.chunk_index[1:0]];
        lookup_ok   = 1'b1;
      end
      CHUNK_COUNTER: if (chunk_if.chunk_index == 5'd0) begin
        lookup_data = counter_q;
        lookup_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    key_d        = key_q;
    nonce_d      = nonce_q;
    counter_d    = counter_q;
    auto_inc_d   = auto_inc_q;
    err_d        = err_q;
    ctr_wrap_d   = ctr_wrap_q;
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    data_d       = data_q;
    type_d       = type_q;
    bad_d        = bad_q;
    ctr_hit_d    = ctr_hit_q;
    chunk_d      = chunk_q;
    chunk_type_d = chunk_type_q;
    valid_d      = 1'b0;
    pending_d    = 1'b0;

    // Register writes are applied first so that flag sets and counter
    // increments from the FSM below can be ordered against them.
    if (cfg_we) begin
      if (cfg_addr < ADDR_NONCE0) begin
        key_d[cfg_addr[2:0]] = cfg_wdata;
      end else if (cfg_addr < ADDR_COUNTER) begin
        nonce_d[2'(cfg_addr - ADDR_NONCE0)] = cfg_wdata;
      end else if (cfg_addr == ADDR_COUNTER) begin
        counter_d = cfg_wdata;
      end else if (cfg_addr == ADDR_CTRL) begin
        auto_inc_d = cfg_wdata[0];
        if (cfg_wdata[1]) begin
          err_d      = 1'b0;
          ctr_wrap_d = 1'b0;
        end
      end
    end

    case (state_q)
      IDLE: if (chunk_if.chunk_request) begin
        // Data is captured here so later cfg writes cannot alter the response.
        data_d    = lookup_data;
        type_d    = chunk_if.request_type;
        bad_d     = !lookup_ok;
        ctr_hit_d = lookup_ok && (chunk_if.request_type == CHUNK_COUNTER);
        pending_d = 1'b1;
        if (LATENCY > 1) begin
          state_d   = WAIT;
          lat_cnt_d = LAT_LOAD;
        end else begin
          state_d      = PRESENT;
          chunk_d      = lookup_data;
          chunk_type_d = chunk_if.request_type;
          valid_d      = 1'b1;
        end
      end
      WAIT: begin
        pending_d = 1'b1;
        if (lat_cnt_q == 3'd0) begin
          state_d      = PRESENT;
          chunk_d      = data_q;
          chunk_type_d = type_q;
          valid_d      = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      PRESENT: begin
        state_d = IDLE;
        if (bad_q) err_d = 1'b1;
        // A coincident firmware counter write takes precedence over the increment.
        if (ctr_hit_q && auto_inc_q && !(cfg_we && cfg_addr == ADDR_COUNTER)) begin
          counter_d = counter_q + 32'd1;
          if (counter_q == '1) ctr_wrap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q        <= '{default: '0};
      nonce_q      <= '{default: '0};
      counter_q    <= '0;
      auto_inc_q   <= 1'b0;
      err_q        <= 1'b0;
      ctr_wrap_q   <= 1'b0;
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      data_q       <= '0;
      type_q       <= '0;
      bad_q        <= 1'b0;
      ctr_hit_q    <= 1'b0;
      chunk_q      <= '0;
      chunk_type_q <= '0;
      valid_q      <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      key_q        <= key_d;
      nonce_q      <= nonce_d;
      counter_q    <= counter_d;
      auto_inc_q   <= auto_inc_d;
      err_q        <= err_d;
      ctr_wrap_q   <= ctr_wrap_d;
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      data_q       <= data_d;
      type_q       <= type_d;
      bad_q        <= bad_d;
      ctr_hit_q    <= ctr_hit_d;
      chunk_q      <= chunk_d;
      chunk_type_q <= chunk_type_d;
      valid_q      <= valid_d;
      pending_q    <= pending_d;
    end
  end

  assign chunk_if.chunk       = chunk_q;
  assign chunk_if.chunk_type  = chunk_type_q;
  assign chunk_if.chunk_valid = valid_q;
  assign chunk_if.pending     = pending_q;
  assign counter_value        = counter_q;
  assign err                  = err_q;
  assign ctr_wrap             = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_chunk_server.sv
// Directed bench for chacha_chunk_server: three instances at LATENCY 1, 4, 3.
module tb_chacha_chunk_server;

  logic        clk;
  logic        rst   [3];
  logic        we    [3];
  logic [3:0]  addr  [3];
  logic [31:0] wdata [3];
  logic        req   [3];
  logic [1:0]  rtype [3];
  logic [4:0]  ridx  [3];
  logic [31:0] ch    [3];
  logic [1:0]  cht   [3];
  logic        vld   [3];
  logic        pnd   [3];
  logic [31:0] cval  [3];
  logic        errs  [3];
  logic        wraps [3];

  int n_checks = 0;
  int n_pass   = 0;

  chacha_chunk_server_if if0 ();
  chacha_chunk_server_if if1 ();
  chacha_chunk_server_if if2 ();

  assign if0.chunk_request = req[0];
  assign if0.request_type  = rtype[0];
  assign if0.chunk_index   = ridx[0];
  assign ch[0]  = if0.chunk;
  assign cht[0] = if0.chunk_type;
  assign vld[0] = if0.chunk_valid;
  assign pnd[0] = if0.pending;

  assign if1.chunk_request = req[1];
  assign if1.request_type  = rtype[1];
  assign if1.chunk_index   = ridx[1];
  assign ch[1]  = if1.chunk;
  assign cht[1] = if1.chunk_type;
  assign vld[1] = if1.chunk_valid;
  assign pnd[1] = if1.pending;

  assign if2.chunk_request = req[2];
  assign if2.request_type  = rtype[2];
  assign if2.chunk_index   = ridx[2];
  assign ch[2]  = if2.chunk;
  assign cht[2] = if2.chunk_type;
  assign vld[2] = if2.chunk_valid;
  assign pnd[2] = if2.pending;

  chacha_chunk_server #(.LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst[0]), .cfg_we(we[0]), .cfg_addr(addr[0]), .cfg_wdata(wdata[0]),
    .chunk_if(if0), .counter_value(cval[0]), .err(errs[0]), .ctr_wrap(wraps[0])
  );
  chacha_chunk_server #(.LATENCY(4)) u_dut1 (
    .clk(clk), .rst(rst[1]), .cfg_we(we[1]), .cfg_addr(addr[1]), .cfg_wdata(wdata[1]),
    .chunk_if(if1), .counter_value(cval[1]), .err(errs[1]), .ctr_wrap(wraps[1])
  );
  chacha_chunk_server #(.LATENCY(3)) u_dut2 (
    .clk(clk), .rst(rst[2]), .cfg_we(we[2]), .cfg_addr(addr[2]), .cfg_wdata(wdata[2]),
    .chunk_if(if2), .counter_value(cval[2]), .err(errs[2]), .ctr_wrap(wraps[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic cfg_write(input int d, input logic [3:0] a, input logic [31:0] v);
    we[d] = 1'b1; addr[d] = a; wdata[d] = v;
    @(posedge clk); #1;
    we[d] = 1'b0;
  endtask

  // Issues one request, waits (bounded) for the response and checks the pulse is one cycle.
  task automatic do_request(input int d, input logic [1:0] t, input logic [4:0] i,
                            output logic [31:0] data, output logic [1:0] typ, output int lat);
    rtype[d] = t; ridx[d] = i; req[d] = 1'b1;
    @(posedge clk); #1;
    req[d] = 1'b0;
    lat = 1;
    while (!vld[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data = ch[d];
    typ  = cht[d];
    @(posedge clk); #1;
    check_eq("valid_one_cycle", 32'(vld[d]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] data;
    logic [1:0]  typ;
    int          lat;
    logic [19:0] vmask, pmask, exp_v, exp_p;
    logic        seen;
    int          k;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      req[d] = 1'b0; rtype[d] = '0; ridx[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_chunk",   ch[0], 32'h0);
    check_eq("rst_valid",   32'(vld[0]), 32'd0);
    check_eq("rst_pending", 32'(pnd[0]), 32'd0);
    check_eq("rst_counter", cval[0], 32'h0);
    check_eq("rst_err",     32'(errs[0]), 32'd0);
    check_eq("rst_wrap",    32'(wraps[0]), 32'd0);

    // Key readback, LATENCY=1
    for (int i = 0; i < 8; i++) cfg_write(0, 4'(i), 32'h03020100 + 32'(i) * 32'h04040404);
    for (int i = 0; i < 8; i++) begin
      do_request(0, 2'd0, 5'(i), data, typ, lat);
      check_eq($sformatf("key%0d_data", i), data, 32'h03020100 + 32'(i) * 32'h04040404);
      check_eq($sformatf("key%0d_type", i), 32'(typ), 32'd0);
      check_eq($sformatf("key%0d_lat", i), 32'(lat), 32'd1);
    end

    // Nonce readback
    cfg_write(0, 4'd10, 32'hA5A5_0002);
    do_request(0, 2'd1, 5'd2, data, typ, lat);
    check_eq("nonce2_data", data, 32'hA5A5_0002);
    check_eq("nonce2_type", 32'(typ), 32'd1);

    // Counter auto-increment wrap
    cfg_write(0, 4'd11, 32'hFFFF_FFFF);
    cfg_write(0, 4'd12, 32'h1);
    do_request(0, 2'd2, 5'd0, data, typ, lat);
    check_eq("wrap_resp0", data, 32'hFFFF_FFFF);
    check_eq("wrap_type",  32'(typ), 32'd2);
    check_eq("wrap_ctr0",  cval[0], 32'h0);
    check_eq("wrap_flag",  32'(wraps[0]), 32'd1);
    do_request(0, 2'd2, 5'd0, data, typ, lat);
    check_eq("wrap_resp1", data, 32'h0);
    check_eq("wrap_ctr1",  cval[0], 32'h1);
    check_eq("err_clean",  32'(errs[0]), 32'd0);

    // Illegal requests
    do_request(0, 2'd1, 5'd3, data, typ, lat);
    check_eq("bad_nonce_data", data, 32'h0);
    check_eq("bad_nonce_lat",  32'(lat), 32'd1);
    check_eq("bad_nonce_err",  32'(errs[0]), 32'd1);
    do_request(0, 2'd3, 5'd0, data, typ, lat);
    check_eq("bad_type_data", data, 32'h0);
    check_eq("bad_type_type", 32'(typ), 32'd3);
    check_eq("bad_type_err",  32'(errs[0]), 32'd1);
    cfg_write(0, 4'd12, 32'h2);
    check_eq("clr_err",  32'(errs[0]), 32'd0);
    check_eq("clr_wrap", 32'(wraps[0]), 32'd0);

    // LATENCY=4 with request held high
    cfg_write(1, 4'd2, 32'hCAFE_F00D);
    rtype[1] = 2'd0; ridx[1] = 5'd2; req[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vmask[i] = vld[1];
      pmask[i] = pnd[1];
      exp_v[i] = ((i % 5) == 3);
      exp_p[i] = ((i % 5) != 4);
      if (i == 3) check_eq("lat4_data", ch[1], 32'hCAFE_F00D);
    end
    req[1] = 1'b0;
    check_eq("lat4_valid_mask",   32'(vmask), 32'(exp_v));
    check_eq("lat4_pending_mask", 32'(pmask), 32'(exp_p));
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-flight, LATENCY=3
    cfg_write(2, 4'd0, 32'h1111_1111);
    cfg_write(2, 4'd11, 32'h22);
    cfg_write(2, 4'd12, 32'h1);
    rtype[2] = 2'd2; ridx[2] = 5'd0; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    check_eq("mid_pending_pre", 32'(pnd[2]), 32'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    #1;
    check_eq("mid_pending_rst", 32'(pnd[2]), 32'd0);
    check_eq("mid_valid_rst",   32'(vld[2]), 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | vld[2];
    end
    check_eq("mid_no_valid", 32'(seen), 32'd0);
    check_eq("mid_counter",  cval[2], 32'h0);
    do_request(2, 2'd0, 5'd0, data, typ, lat);
    check_eq("mid_key0",  data, 32'h0);
    check_eq("lat3_lat",  32'(lat), 32'd3);
    do_request(2, 2'd2, 5'd0, data, typ, lat);
    check_eq("mid_autoinc_off", cval[2], 32'h0);

    // Write collision with auto-increment
    cfg_write(2, 4'd11, 32'h5);
    cfg_write(2, 4'd12, 32'h1);
    rtype[2] = 2'd2; ridx[2] = 5'd0; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    k = 0;
    while (!vld[2] && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("coll_lat",  32'(k), 32'd2);
    check_eq("coll_resp", ch[2], 32'h5);
    we[2] = 1'b1; addr[2] = 4'd11; wdata[2] = 32'h100;
    @(posedge clk); #1;
    we[2] = 1'b0;
    check_eq("coll_ctr", cval[2], 32'h100);
    do_request(2, 2'd2, 5'd0, data, typ, lat);
    check_eq("post_coll_resp", data, 32'h100);
    check_eq("post_coll_ctr",  cval[2], 32'h101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chacha_chunk_server.md
# chacha_chunk_server

Upstream key/nonce/counter source for the ChaCha20 top-level. Firmware loads an 8-word key, 3-word nonce, 32-bit block counter and control bits through a register write port. The block answers the top-level's streamed-chunk requests (`chunk_request`/`request_type`/`chunk_index`) with one-cycle `chunk_valid` responses after a fixed latency. Optionally, it auto-increments the block counter each time the counter word is served, so successive blocks use consecutive counters.

## Interface
Parameters:
- LATENCY, 1: cycles from accepted request to `chunk_valid`; legal range 1..7.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  register write strobe
- cfg_addr  in  4  0–7 key word 0–7; 8–10 nonce word 0–2; 11 counter; 12 control (bit0 auto_inc, bit1 clear flags, self-clearing); 13–15 ignored
- cfg_wdata  in  32  write data
- chunk_request  in  1  request from consumer
- request_type  in  2  0 KEY, 1 NONCE, 2 COUNTER, 3 reserved
- chunk_index  in  5  word index within type
- chunk  out  32  response data
- chunk_type  out  2  type of the response, equal to the latched `request_type`
- chunk_valid  out  1  response strobe, exactly one cycle
- pending  out  1  request accepted, response not yet presented
- counter_value  out  32  current stored counter
- err  out  1  sticky: illegal type/index served
- ctr_wrap  out  1  sticky: auto-increment wrapped 0xFFFFFFFF→0

## Operation
- Reset values:
  - Key, nonce, counter, control all 0.
  - FSM in IDLE.
  - All outputs 0.
- FSM:
  - IDLE: `chunk_request`=1 → latch type/index, look up data, → WAIT (LATENCY>1) or PRESENT (LATENCY=1).
  - WAIT: count LATENCY−1 cycles → PRESENT.
  - PRESENT: `chunk_valid`=1 for this cycle only → IDLE.
- `pending`=1 in WAIT and PRESENT.
- Requests in WAIT or PRESENT are ignored, not queued. The consumer re-issues.
- Data lookup:
  - KEY idx 0–7 → key word idx.
  - NONCE idx 0–2 → nonce word idx.
  - COUNTER idx 0 → counter.
  - Any other type/index → `chunk`=0, still valid, `err` set.
- Data is captured at acceptance. A later cfg write does not alter an in-flight response.
- `chunk`/`chunk_type` hold their last values outside PRESENT.
- Auto-increment: on the PRESENT cycle of a legal COUNTER response with auto_inc=1, counter ← counter+1 mod 2^32. On wrap, set `ctr_wrap`.
- Same-cycle cfg write to addr 11 and auto-increment: the cfg write wins; the increment is dropped.
- Control write with bit1=1 clears `err` and `ctr_wrap`. If a set event occurs in the same cycle, the set wins.
- Writes to addr 12 update only auto_inc from bit0.

## Timing
- Request sampled at edge T (in IDLE) → `chunk_valid` high in cycle T+LATENCY → IDLE in T+LATENCY+1.
- Earliest next accepted request is at T+LATENCY+1. Back-to-back throughput is one word per LATENCY+1 cycles.
- Outputs are registered; no combinational path from the request inputs to `chunk`/`chunk_valid`.
- `counter_value` reflects an increment in the cycle after PRESENT.
- A cfg write is visible to a request accepted in the next cycle or later.
- Reset asserted mid-WAIT/PRESENT: the FSM returns to IDLE immediately and `chunk_valid` is deasserted asynchronously. No response or increment occurs after reset release.

## Structure
- Shared package `chacha_chunk_pkg` holds:
  - type encodings (CHUNK_KEY=2'd0, CHUNK_NONCE=2'd1, CHUNK_COUNTER=2'd2);
  - cfg address map constants;
  - the FSM state encoding (IDLE, WAIT, PRESENT);
  - word counts (KEY_WORDS=8, NONCE_WORDS=3).
- Single module, no sub-module: register file, lookup mux, latency counter and FSM are small enough to live together.

## Test plan
- Key readback: write key words 0x03020100…0x1F1E1D1C, LATENCY=1; request KEY idx 0..7 → each `chunk_valid` one cycle after its request with matching word, `chunk_type`=0.
- Counter auto-increment wrap: counter=0xFFFFFFFF, auto_inc=1; two COUNTER idx 0 requests → responses 0xFFFFFFFF then 0x00000000; `ctr_wrap`=1, `counter_value`=1.
- Illegal request: NONCE idx 3, then type 3 idx 0 → both respond `chunk`=0 with valid; `err`=1; control write 0x2 → `err`=0.
- Latency and ignored requests: LATENCY=4; hold `chunk_request` high continuously on KEY idx 2 → valid at T+4, exactly one pulse per 5 cycles; `pending` high 4 cycles each.
- Reset mid-flight: LATENCY=3; assert `rst` one cycle after acceptance → `chunk_valid` never pulses; all registers 0; `pending`=0.
- Write collision: auto_inc=1, counter=5; cfg write 0x100 to addr 11 coincident with the COUNTER PRESENT cycle → response 5, `counter_value`=0x100 afterwards.
